pool_tile_builder: RTL and testbench

Streaming front end for the pooling stage. It accepts a raster-scan pixel stream (one signed 32-bit word per handshake) and buffers it in two ping-pong 4-row banks. It emits non-overlapping 4×4 tiles, one per handshake, in left-to-right order for each 4-row band. Its tile output feeds the 4×4→2×2 max-pool combinational stage directly, and the pool output then goes to ReLU.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pool_tile_builder_tile_bank.sv | 32 +++
 rtl/pool_tile_builder.sv | 124 ++++++++++++
 tb/tb_pool_tile_builder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants for the pooling front end.
package cnn_pkg;
  localparam int PIXEL_W  = 32;
  localparam int TILE_DIM = 4;

  typedef logic signed [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [TILE_DIM-1:0][TILE_DIM-1:0] tile4_t;
  typedef pixel_t [1:0][1:0] pool2_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_tile_builder_tile_bank.sv
// One 4-row band store: single pixel write port, full 4x4 tile read port.
module tile_bank
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 8,
  localparam int TILES_X = IMG_W / TILE_DIM,
  localparam int TX_W    = idx_w(TILES_X)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [1:0]              row_i,
  input  logic [TX_W-1:0]         col_tile_i,
  input  logic [1:0]              col_sub_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic [TX_W-1:0]         rd_tile_i,
  output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] tile_o
);
  // Column split as {tile, column-within-tile} so a whole tile is one slice.
  logic [TILE_DIM-1:0][TILES_X-1:0][TILE_DIM-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mem_q <= '0;
    else if (we_i) mem_q[row_i][col_tile_i][col_sub_i] <= data_i;
  end

  always_comb begin
    tile_o = '0;
    for (int r = 0; r < TILE_DIM; r++) tile_o[r] = mem_q[r][rd_tile_i];
  end
endmodule

// File: rtl/pool_tile_builder.sv
// Raster pixel stream in, 4x4 tiles out, via two ping-pong 4-row banks.
module pool_tile_builder
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  localparam int TILES_X = IMG_W / TILE_DIM,
  localparam int BANDS   = IMG_H / TILE_DIM,
  localparam int TX_W    = idx_w(TILES_X),
  localparam int BW      = idx_w(BANDS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] m_tile,
  output logic [TX_W-1:0]          m_tile_x,
  output logic [BW-1:0]            m_band,
  output logic                     m_frame_last
);
  localparam logic [TX_W-1:0] TX_LAST   = TX_W'(TILES_X - 1);
  localparam logic [BW-1:0]   BAND_LAST = BW'(BANDS - 1);

  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [TX_W-1:0] wr_tile_q, wr_tile_d, rd_tile_q, rd_tile_d;
  logic [1:0]      wr_sub_q, wr_sub_d, wr_row_q, wr_row_d;
  logic [BW-1:0]   wr_band_q, wr_band_d, rd_band_q, rd_band_d;
  logic [1:0]      full_q, full_d;
  logic            in_hs, out_hs;
  logic [1:0][TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] bank_tile;

  // Ready/valid come only from flops, so neither side sees the other combinationally.
  assign s_ready      = !full_q[wr_bank_q];
  assign m_valid      = full_q[rd_bank_q];
  assign in_hs        = s_valid && s_ready;
  assign out_hs       = m_valid && m_ready;
  assign m_tile       = bank_tile[rd_bank_q];
  assign m_tile_x     = rd_tile_q;
  assign m_band       = rd_band_q;
  assign m_frame_last = m_valid && (rd_tile_q == TX_LAST) && (rd_band_q == BAND_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (in_hs && (wr_bank_q == 1'(b))),
      .row_i      (wr_row_q),
      .col_tile_i (wr_tile_q),
      .col_sub_i  (wr_sub_q),
      .data_i     (s_data),
      .rd_tile_i  (rd_tile_q),
      .tile_o     (bank_tile[b])
    );
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_tile_d = wr_tile_q;
    wr_sub_d  = wr_sub_q;
    wr_row_d  = wr_row_q;
    wr_band_d = wr_band_q;
    rd_bank_d = rd_bank_q;
    rd_tile_d = rd_tile_q;
    rd_band_d = rd_band_q;
    full_d    = full_q;

    if (out_hs) begin
      if (rd_tile_q == TX_LAST) begin
        rd_tile_d         = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_band_d         = (rd_band_q == BAND_LAST) ? '0 : BW'(rd_band_q + 1);
      end else begin
        rd_tile_d = TX_W'(rd_tile_q + 1);
      end
    end

    // A band can complete while the other bank finishes draining; flags differ.
    if (in_hs) begin
      wr_sub_d = wr_sub_q + 2'd1;
      if (wr_sub_q == 2'd3) begin
        if (wr_tile_q == TX_LAST) begin
          wr_tile_d = '0;
          wr_row_d  = wr_row_q + 2'd1;
          if (wr_row_q == 2'd3) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_band_d         = (wr_band_q == BAND_LAST) ? '0 : BW'(wr_band_q + 1);
          end
        end else begin
          wr_tile_d = TX_W'(wr_tile_q + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_tile_q <= '0;
      wr_sub_q  <= '0;
      wr_row_q  <= '0;
      wr_band_q <= '0;
      rd_bank_q <= 1'b0;
      rd_tile_q <= '0;
      rd_band_q <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_tile_q <= wr_tile_d;
      wr_sub_q  <= wr_sub_d;
      wr_row_q  <= wr_row_d;
      wr_band_q <= wr_band_d;
      rd_bank_q <= rd_bank_d;
      rd_tile_q <= rd_tile_d;
      rd_band_q <= rd_band_d;
      full_q    <= full_d;
    end
  end
endmodule

// File: tb/tb_pool_tile_builder.sv
// Self-checking bench: frame-level tile model, spot-value table, corner sequences.
module tb_pool_tile_builder;
  localparam int DATA_W   = 32;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 12;
  localparam int TX       = IMG_W / 4;
  localparam int BANDS    = IMG_H / 4;
  localparam int BAND_PIX = 4 * IMG_W;

  typedef logic [3:0][3:0][DATA_W-1:0] tile_t;
  typedef struct { tile_t t; int x; int band; bit last; } exp_t;
  typedef struct { int idx; int r; int c; int val; int x; int band; bit last; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic s_ready, m_valid, m_frame_last;
  tile_t m_tile;
  logic [0:0] m_tile_x;
  logic [1:0] m_band;

  pool_tile_builder #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_tile(m_tile), .m_tile_x(m_tile_x),
    .m_band(m_band), .m_frame_last(m_frame_last));

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  logic [DATA_W-1:0] pix_q[$];
  exp_t exp_q[$];
  exp_t seen_q[$];
  int bands_c = 0, tiles_t = 0, pix_cnt = 0;
  bit capture = 0, hs_in = 0, hs_out = 0;
  vec_t vecs[10];

  function automatic void chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else pass_cnt++;
  endfunction

  function automatic void chk_tile(input exp_t e);
    total_cnt++;
    if (m_tile !== e.t || int'(m_tile_x) != e.x || int'(m_band) != e.band || m_frame_last !== e.last)
      $display("FAIL tile: got x=%0d band=%0d last=%0b %h expected x=%0d band=%0d last=%0b %h",
               m_tile_x, m_band, m_frame_last, m_tile, e.x, e.band, e.last, e.t);
    else pass_cnt++;
  endfunction

  // Model: a frame is a 2-D array; each band yields TX tiles in x order.
  task automatic push_frame(input bit ramp);
    logic [DATA_W-1:0] f[IMG_H][IMG_W];
    exp_t e;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        f[r][c] = ramp ? DATA_W'(IMG_W * r + c) : $urandom;
        pix_q.push_back(f[r][c]);
      end
    for (int b = 0; b < BANDS; b++)
      for (int x = 0; x < TX; x++) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) e.t[r][c] = f[4*b+r][4*x+c];
        e.x = x; e.band = b; e.last = (b == BANDS-1) && (x == TX-1);
        exp_q.push_back(e);
      end
  endtask

  // Sample at negedge, then return 1 time unit after the next posedge.
  task automatic cycle();
    int undrained;
    exp_t e;
    @(negedge clk);
    hs_in = 0; hs_out = 0;
    undrained = bands_c - tiles_t / TX;
    chk("s_ready", longint'(s_ready), longint'(undrained < 2));
    chk("m_valid", longint'(m_valid), longint'(undrained > 0));
    if (m_valid) begin
      if (exp_q.size() == 0) chk("extra_tile", 1, 0);
      else chk_tile(exp_q[0]);
      if (m_ready) begin
        hs_out = 1;
        tiles_t++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (capture) seen_q.push_back(e);
        end
      end
    end
    if (s_valid && s_ready) begin
      hs_in = 1;
      void'(pix_q.pop_front());
      pix_cnt++;
      if (pix_cnt % BAND_PIX == 0) bands_c++;
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input bit v, input bit r);
    s_valid = v && (pix_q.size() > 0);
    s_data  = s_valid ? pix_q[0] : $urandom;
    m_ready = r;
    cycle();
  endtask

  task automatic run(input int vpct, input int rpct, input int maxc);
    int n = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
      step($urandom_range(99) < vpct, $urandom_range(99) < rpct);
      n++;
    end
    chk("drain_timeout_left", pix_q.size() + exp_q.size(), 0);
    s_valid = 0; m_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0; m_ready = 0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_tile_zero", longint'(m_tile == '0), 1);
    chk("rst_tile_x", m_tile_x, 0);
    chk("rst_band", m_band, 0);
    chk("rst_frame_last", m_frame_last, 0);
    pix_q.delete(); exp_q.delete();
    bands_c = 0; tiles_t = 0; pix_cnt = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{0, 3, 3, 27, 0, 0, 0};
    vecs[2] = '{1, 0, 0,  4, 1, 0, 0};
    vecs[3] = '{1, 3, 3, 31, 1, 0, 0};
    vecs[4] = '{2, 0, 0, 32, 0, 1, 0};
    vecs[5] = '{2, 3, 3, 59, 0, 1, 0};
    vecs[6] = '{3, 0, 0, 36, 1, 1, 0};
    vecs[7] = '{3, 3, 3, 63, 1, 1, 0};
    vecs[8] = '{4, 2, 1, 81, 0, 2, 0};
    vecs[9] = '{5, 3, 3, 95, 1, 2, 1};

    #1;
    do_reset();

    // Basic ramp frame, continuous flow both sides
    capture = 1;
    push_frame(1);
    run(100, 100, 400);
    capture = 0;
    chk("basic_tile_count", seen_q.size(), TX * BANDS);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].idx < seen_q.size()) begin
        exp_t e;
        e = seen_q[vecs[i].idx];
        chk($sformatf("vec%0d_val", i), longint'(e.t[vecs[i].r][vecs[i].c]), vecs[i].val);
        chk($sformatf("vec%0d_x", i), e.x, vecs[i].x);
        chk($sformatf("vec%0d_band", i), e.band, vecs[i].band);
        chk($sformatf("vec%0d_last", i), longint'(e.last), longint'(vecs[i].last));
      end else chk($sformatf("vec%0d_missing", i), 0, 1);
    end

    // Both banks full, output stalled, then a two-tile drain frees bank 0
    do_reset();
    push_frame(0);
    for (int i = 0; i < 80; i++) step(1, 0);
    chk("full_pix_accepted", pix_cnt, 64);
    chk("full_s_ready_low", s_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      chk("stall_tile_x", m_tile_x, 0);
      chk("stall_band", m_band, 0);
    end
    step(1, 1);
    step(1, 1);
    chk("freed_s_ready", s_ready, 1);
    run(100, 100, 500);

    // Last pixel of band 1 accepted with the last tile of band 0
    do_reset();
    push_frame(0);
    for (int i = 0; i < 63; i++) step(1, 0);
    step(0, 1);
    step(1, 1);
    chk("sim_in_hs", hs_in, 1);
    chk("sim_out_hs", hs_out, 1);
    chk("sim_m_valid", m_valid, 1);
    chk("sim_band", m_band, 1);
    chk("sim_tile_x", m_tile_x, 0);
    chk("sim_s_ready", s_ready, 1);
    run(100, 100, 500);

    // Reset after 20 pixels, then a fresh ramp frame
    do_reset();
    push_frame(0);
    for (int i = 0; i < 20; i++) step(1, 1);
    do_reset();
    push_frame(1);
    run(100, 100, 500);

    // Back-to-back frames, band index wraps; then random handshakes
    push_frame(0);
    push_frame(0);
    run(100, 100, 1000);
    for (int k = 0; k < 6; k++) begin
      push_frame(0);
      push_frame(0);
      run($urandom_range(30, 100), $urandom_range(20, 100), 4000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
